// File: rtl/prt_scaler_hrep.sv
// Horizontal pixel-repeat stage: pulls pixels from the scaler FIFO
// through a credit-limited skid buffer and emits each one 1..8 times.
module prt_scaler_hrep #(
  parameter int P_DAT_WIDTH = 24,
  parameter int P_LEN_WIDTH = 13
) (
  input  logic                   CLK_IN,
  input  logic                   RST_IN,
  input  logic                   CTL_RUN_IN,
  input  logic [2:0]             CFG_FACTOR_IN,
  input  logic [P_LEN_WIDTH-1:0] CFG_LEN_IN,
  input  logic                   FIFO_EP_IN,
  output logic                   FIFO_RD_OUT,
  input  logic [P_DAT_WIDTH-1:0] FIFO_DAT_IN,
  input  logic                   FIFO_DE_IN,
  output logic [P_DAT_WIDTH-1:0] SRC_DAT_OUT,
  output logic                   SRC_VLD_OUT,
  input  logic                   SRC_RDY_IN,
  output logic                   SRC_EOL_OUT,
  output logic                   STA_OVF_OUT
);

  localparam logic [P_LEN_WIDTH-1:0] LEN_ONE = 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             fac_q, fac_d;
  logic [2:0]             rep_q, rep_d;
  logic [P_LEN_WIDTH-1:0] last_q, last_d;
  logic [P_LEN_WIDTH-1:0] pix_q, pix_d;
  logic [P_DAT_WIDTH-1:0] mem_q [4];
  logic [1:0]             wptr_q, rptr_q;
  logic [2:0]             occ_q, occ_d;
  logic                   rd1_q, rd2_q;
  logic                   vld_q, vld_d;
  logic [P_DAT_WIDTH-1:0] dat_q, dat_d;
  logic                   ovf_q;

  logic [2:0] credit;
  logic       hs;
  logic       last_rep;
  logic       eol;
  logic       wr;
  logic       pop;
  logic       latch;
  logic       leave;

  assign credit   = occ_q + {2'b00, rd1_q} + {2'b00, rd2_q};
  assign last_rep = (rep_q == fac_q);
  assign hs       = vld_q && SRC_RDY_IN;
  assign eol      = vld_q && (pix_q == last_q) && last_rep;
  assign leave    = hs && eol && !CTL_RUN_IN;
  assign wr       = FIFO_DE_IN && (occ_q != 3'd4);

  // Leaving ACTIVE at EOL must not pull the next pixel into the register.
  assign pop = (state_q == S_ACTIVE) && !leave && (occ_q != 3'd0) &&
               (!vld_q || (hs && last_rep));

  assign occ_d = occ_q + {2'b00, wr} - {2'b00, pop};

  assign FIFO_RD_OUT = (state_q == S_ACTIVE) && !FIFO_EP_IN &&
                       (credit < 3'd4);
  assign SRC_DAT_OUT = dat_q;
  assign SRC_VLD_OUT = vld_q;
  assign SRC_EOL_OUT = eol;
  assign STA_OVF_OUT = ovf_q;

  // Run control, line config latch and repeat/pixel counters.
  always_comb begin
    state_d = state_q;
    fac_d   = fac_q;
    last_d  = last_q;
    rep_d   = rep_q;
    pix_d   = pix_q;
    latch   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CTL_RUN_IN) begin
          state_d = S_ACTIVE;
          latch   = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (hs && eol) begin
          if (!CTL_RUN_IN) state_d = S_IDLE;
          else             latch   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (hs) begin
      if (last_rep) begin
        rep_d = 3'd0;
        pix_d = eol ? '0 : pix_q + LEN_ONE;
      end else begin
        rep_d = rep_q + 3'd1;
      end
    end
    if (latch) begin
      fac_d  = CFG_FACTOR_IN;
      last_d = (CFG_LEN_IN == '0) ? '0 : CFG_LEN_IN - LEN_ONE;
      rep_d  = 3'd0;
      pix_d  = '0;
    end
  end

  // Output register: release after last repeat, reload from buffer.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (hs && last_rep) vld_d = 1'b0;
    if (pop) begin
      vld_d = 1'b1;
      dat_d = mem_q[rptr_q];
    end
  end

  // State, buffer, credit pipeline and sticky overflow registers.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state_q <= S_IDLE;
      fac_q   <= '0;
      last_q  <= '0;
      rep_q   <= '0;
      pix_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      rd1_q   <= 1'b0;
      rd2_q   <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fac_q   <= fac_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
      pix_q   <= pix_d;
      occ_q   <= occ_d;
      rd1_q   <= FIFO_RD_OUT;
      rd2_q   <= rd1_q;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      if (wr) begin
        mem_q[wptr_q] <= FIFO_DAT_IN;
        wptr_q        <= wptr_q + 2'd1;
      end
      if (pop) rptr_q <= rptr_q + 2'd1;
      if (FIFO_DE_IN && (occ_q == 3'd4)) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prt_scaler_hrep.sv
// Bench for prt_scaler_hrep: FIFO model with 2-cycle read latency,
// pixel-stream scoreboard and credit bound check.
module tb_prt_scaler_hrep;

  localparam int DW = 24;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [2:0]    fac = 3'd0;
  logic [LW-1:0] len = 13'd4;
  logic          fifo_ep = 1'b1;
  logic          fifo_rd;
  logic [DW-1:0] fifo_dat;
  logic          fifo_de;
  logic [DW-1:0] src_dat;
  logic          src_vld;
  logic          src_rdy = 1'b1;
  logic          src_eol;
  logic          ovf;

  logic          m_de = 1'b0;
  logic [DW-1:0] m_dat = '0;
  logic          f_de = 1'b0;
  logic [DW-1:0] f_dat = '0;
  logic          rd_p1 = 1'b0;
  logic [DW-1:0] dat_p1 = '0;

  assign fifo_de  = m_de | f_de;
  assign fifo_dat = f_de ? f_dat : m_dat;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] pix_q[$];
  logic [DW-1:0] exp_dat[$];
  logic          exp_eol[$];
  logic          exp_lst[$];

  int   cyc = 0;
  logic mon_en = 1'b1;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  int   rd_cnt = 0;
  int   done_cnt = 0;
  int   sum_c = 0;
  int   beat_cnt = 0;
  int   eol_idx = -1;
  int   eol_cyc = -1;
  int   first_rd = -1;
  int   first_vld = -1;
  logic [DW-1:0] e_d;
  logic          e_e;
  logic          e_l;

  always #5 clk = ~clk;

  prt_scaler_hrep #(
    .P_DAT_WIDTH(DW),
    .P_LEN_WIDTH(LW)
  ) dut (
    .CLK_IN       (clk),
    .RST_IN       (rst),
    .CTL_RUN_IN   (run),
    .CFG_FACTOR_IN(fac),
    .CFG_LEN_IN   (len),
    .FIFO_EP_IN   (fifo_ep),
    .FIFO_RD_OUT  (fifo_rd),
    .FIFO_DAT_IN  (fifo_dat),
    .FIFO_DE_IN   (fifo_de),
    .SRC_DAT_OUT  (src_dat),
    .SRC_VLD_OUT  (src_vld),
    .SRC_RDY_IN   (src_rdy),
    .SRC_EOL_OUT  (src_eol),
    .STA_OVF_OUT  (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // FIFO read port: data and DE appear two cycles after the read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_p1 <= (fifo_rd === 1'b1);
    if (fifo_rd === 1'b1 && fq.size() != 0) dat_p1 <= fq.pop_front();
    m_de <= rd_p1;
    m_dat <= dat_p1;
    fifo_ep <= (fq.size() == 0);
  end

  // Scoreboard, stall stability and credit bound.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      sum_c = rd_cnt - done_cnt - (src_vld ? 1 : 0) + (fifo_rd ? 1 : 0);
      if (sum_c > 4) chk("credit", sum_c, 4);
      if (prev_stall) begin
        chk("hold_vld", {31'd0, src_vld}, 1);
        chk("hold_dat", src_dat, prev_dat);
      end
      if (fifo_rd) begin
        if (first_rd < 0) first_rd = cyc;
        rd_cnt++;
      end
      if (src_vld && first_vld < 0) first_vld = cyc;
      if (src_vld && src_rdy) begin
        beat_cnt++;
        if (exp_dat.size() == 0) begin
          chk("extra_beat", src_dat, 32'hFFFFFFFF);
        end else begin
          e_d = exp_dat.pop_front();
          e_e = exp_eol.pop_front();
          e_l = exp_lst.pop_front();
          chk("dat", src_dat, e_d);
          chk("eol", {31'd0, src_eol}, {31'd0, e_e});
          if (e_l) done_cnt++;
        end
        if (src_eol) begin
          eol_idx = beat_cnt;
          eol_cyc = cyc;
        end
      end
      prev_stall = src_vld && !src_rdy;
      prev_dat   = src_dat;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fq.push_back(d);
    pix_q.push_back(d);
  endtask

  task automatic expect_line(input int f, input int l);
    logic [DW-1:0] d;
    for (int i = 0; i < l; i++) begin
      d = pix_q.pop_front();
      for (int r = 0; r < f; r++) begin
        exp_dat.push_back(d);
        exp_eol.push_back(i == l - 1 && r == f - 1);
        exp_lst.push_back(r == f - 1);
      end
    end
  endtask

  task automatic wait_done(input int cap);
    int i;
    i = 0;
    while (i < cap && (exp_dat.size() != 0 || src_vld === 1'b1)) begin
      step(1);
      i++;
    end
    chk("drain", exp_dat.size(), 0);
  endtask

  task automatic wait_beats(input int n, input int cap);
    int i;
    i = 0;
    while (i < cap && beat_cnt < n) begin
      step(1);
      i++;
    end
    if (beat_cnt < n) chk("beat_wait", beat_cnt, n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    step(3);
    chk("rst_rd", {31'd0, fifo_rd}, 0);
    chk("rst_vld", {31'd0, src_vld}, 0);
    chk("rst_eol", {31'd0, src_eol}, 0);
    chk("rst_dat", src_dat, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    rst = 1'b0;
    step(1);

    // x1, L=4, latency and back-to-back beats
    fac = 3'd0;
    len = 13'd4;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    expect_line(1, 4);
    step(1);
    first_rd = -1;
    first_vld = -1;
    beat_cnt = 0;
    run = 1'b1;
    step(2);
    run = 1'b0;
    wait_done(60);
    chk("lat", first_vld - first_rd, 4);
    chk("b2b", eol_cyc - first_vld, 3);
    step(3);
    chk("idle_rd", {31'd0, fifo_rd}, 0);

    // x3, L=2
    fac = 3'd2;
    len = 13'd2;
    push(24'hAAAAAA);
    push(24'hBBBBBB);
    expect_line(3, 2);
    step(1);
    beat_cnt = 0;
    run = 1'b1;
    step(2);
    run = 1'b0;
    wait_done(60);
    chk("eol_beat6", eol_idx, 6);

    // x1, 16 pixels with random back-pressure
    fac = 3'd0;
    len = 13'd16;
    for (int i = 0; i < 16; i++) push(DW'($urandom));
    expect_line(1, 16);
    step(1);
    run = 1'b1;
    step(2);
    run = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_dat.size() == 0 && !src_vld) break;
      src_rdy = ($urandom_range(0, 2) != 0);
      step(1);
    end
    src_rdy = 1'b1;
    wait_done(40);
    chk("bp_ovf", {31'd0, ovf}, 0);

    // run dropped mid-line, leftovers start the next line
    fac = 3'd0;
    len = 13'd4;
    for (int i = 0; i < 6; i++) push(24'h300 + DW'(i));
    expect_line(1, 4);
    step(1);
    beat_cnt = 0;
    run = 1'b1;
    wait_beats(2, 40);
    run = 1'b0;
    wait_done(60);
    step(4);
    chk("rc_idle_rd", {31'd0, fifo_rd}, 0);
    chk("rc_idle_vld", {31'd0, src_vld}, 0);
    len = 13'd2;
    expect_line(1, 2);
    run = 1'b1;
    step(2);
    run = 1'b0;
    wait_done(60);

    // factor change mid-line applies from the next line
    fac = 3'd0;
    len = 13'd3;
    for (int i = 0; i < 6; i++) push(24'h500 + DW'(i));
    expect_line(1, 3);
    expect_line(2, 3);
    step(1);
    beat_cnt = 0;
    run = 1'b1;
    wait_beats(1, 40);
    fac = 3'd1;
    wait_beats(3, 40);
    run = 1'b0;
    wait_done(80);
    chk("cfg_eol_beat9", eol_idx, 9);

    // overflow, then reset mid-line
    mon_en = 1'b0;
    step(2);
    for (int i = 0; i < 4; i++) begin
      f_dat = 24'h100 + DW'(i);
      f_de = 1'b1;
      step(1);
    end
    f_de = 1'b0;
    chk("ovf_at4", {31'd0, ovf}, 0);
    f_dat = 24'h1FF;
    f_de = 1'b1;
    step(1);
    f_de = 1'b0;
    chk("ovf_set", {31'd0, ovf}, 1);
    step(5);
    chk("ovf_sticky", {31'd0, ovf}, 1);
    src_rdy = 1'b0;
    fac = 3'd0;
    len = 13'd4;
    run = 1'b1;
    step(3);
    chk("mid_vld", {31'd0, src_vld}, 1);
    chk("mid_dat", src_dat, 24'h100);
    rst = 1'b1;
    step(1);
    chk("prst_rd", {31'd0, fifo_rd}, 0);
    chk("prst_vld", {31'd0, src_vld}, 0);
    chk("prst_eol", {31'd0, src_eol}, 0);
    chk("prst_dat", src_dat, 0);
    chk("prst_ovf", {31'd0, ovf}, 0);
    rst = 1'b0;
    run = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
